// File: rtl/jtag_shift_capture.sv
// JTAG user-register capture: synchronizes JTAGG signals into clk and shifts DR data into a capture register.
// Optional readback echo of the previous transfer is built when JTAG_SHIFT_CAPTURE_ECHO_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for the first qualified jtck edge of a new transfer
// S_SHIFT | shifting jtdi into sr on each qualified jtck edge
// S_DONE  | publish sr/counter to outputs, pulse valid, return to S_IDLE
module jtag_shift_capture #(
    parameter int C_data_len    = 64,
    parameter int C_sync_stages = 2
) (
    input  logic                  clk,
    input  logic                  resn,
    input  logic                  jtck,
    input  logic                  jtdi,
    input  logic                  jshift,
    input  logic                  jupdate,
    input  logic                  jce1,
    input  logic                  jce2,
    output logic [C_data_len-1:0] data,
    output logic [7:0]            bit_count,
    output logic [1:0]            reg_sel,
    output logic                  overflow,
    output logic                  valid,
    output logic                  jtdo1,
    output logic                  jtdo2
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [8:0] LEN9 = 9'(C_data_len);

    logic [5:0]            sync_pipe [C_sync_stages];
    logic                  jtck_s, jtdi_s, jshift_s, jupdate_s, jce1_s, jce2_s;
    logic                  jtck_q, jupdate_q;
    logic                  shift_en, upd_rise;
    logic [1:0]            state;
    logic [C_data_len-1:0] sr;
    logic [7:0]            cnt;
    logic [1:0]            sel_src;

    // All JTAGG signals share one synchronizer depth so they stay aligned to each other.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            for (int i = 0; i < C_sync_stages; i++) begin
                sync_pipe[i] <= '0;
            end
        end else begin
            sync_pipe[0] <= {jtck, jtdi, jshift, jupdate, jce1, jce2};
            for (int i = 1; i < C_sync_stages; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    assign {jtck_s, jtdi_s, jshift_s, jupdate_s, jce1_s, jce2_s} = sync_pipe[C_sync_stages-1];

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            jtck_q    <= 1'b0;
            jupdate_q <= 1'b0;
        end else begin
            jtck_q    <= jtck_s;
            jupdate_q <= jupdate_s;
        end
    end

    assign shift_en = jtck_s & ~jtck_q & jshift_s & (jce1_s | jce2_s);
    assign upd_rise = jupdate_s & ~jupdate_q;

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state     <= S_IDLE;
            sr        <= '0;
            cnt       <= '0;
            sel_src   <= 2'b00;
            data      <= '0;
            bit_count <= '0;
            reg_sel   <= 2'b00;
            overflow  <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (shift_en) begin
                        sr      <= {jtdi_s, sr[C_data_len-1:1]};
                        cnt     <= 8'd1;
                        sel_src <= jce1_s ? 2'b01 : 2'b10;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // A shift coinciding with the update edge still lands in sr before S_DONE reads it.
                    if (shift_en) begin
                        sr  <= {jtdi_s, sr[C_data_len-1:1]};
                        cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                    end
                    if (upd_rise) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    data      <= sr;
                    bit_count <= cnt;
                    reg_sel   <= sel_src;
                    overflow  <= ({1'b0, cnt} > LEN9);
                    valid     <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef JTAG_SHIFT_CAPTURE_ECHO_EN
    logic [C_data_len-1:0] echo;

    // Echo is loaded with the previous result so the host reads it back while shifting new data in.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            echo <= '0;
        end else if (shift_en && state == S_IDLE) begin
            echo <= data;
        end else if (shift_en && state == S_SHIFT) begin
            echo <= {1'b0, echo[C_data_len-1:1]};
        end
    end

    assign jtdo1 = echo[0] & sel_src[0];
    assign jtdo2 = echo[0] & sel_src[1];
`else
    assign jtdo1 = 1'b0;
    assign jtdo2 = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_shift_capture.sv
// Directed bench for jtag_shift_capture: full, short, overflowing, aborted and echoed transfers.
// Echo expectations follow JTAG_SHIFT_CAPTURE_ECHO_EN; without it jtdo1/jtdo2 must stay 0.
module tb_jtag_shift_capture;

`ifdef JTAG_SHIFT_CAPTURE_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resn, jtck, jtdi, jshift, jupdate, jce1, jce2;
    logic [63:0] data;
    logic [7:0]  bit_count;
    logic [1:0]  reg_sel;
    logic        overflow, valid, jtdo1, jtdo2;

    int          n_pass  = 0;
    int          n_total = 0;
    int          vcount  = 0;
    logic [63:0] exp_data = '0;

    jtag_shift_capture #(.C_data_len(64), .C_sync_stages(2)) dut (
        .clk(clk), .resn(resn), .jtck(jtck), .jtdi(jtdi), .jshift(jshift),
        .jupdate(jupdate), .jce1(jce1), .jce2(jce2), .data(data),
        .bit_count(bit_count), .reg_sel(reg_sel), .overflow(overflow),
        .valid(valid), .jtdo1(jtdo1), .jtdo2(jtdo2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (valid === 1'b1) vcount++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input logic [63:0] d, input logic [7:0] bc,
                                 input logic [1:0] rs, input logic ov);
        check({tag, ".data"}, data, d);
        check({tag, ".bit_count"}, bit_count, bc);
        check({tag, ".reg_sel"}, reg_sel, rs);
        check({tag, ".overflow"}, overflow, ov);
    endtask

    // One qualified jtck cycle; afterwards the echo output must show bit idx of the previous result.
    task automatic shift_bit(input logic b, input logic [63:0] prev, input int idx, input bit on_ce2);
        logic e;
        jtdi   = b;
        jshift = 1'b1;
        wait_clk(8);
        jtck = 1'b1;
        wait_clk(8);
        e = (ECHO && idx < 64) ? prev[idx] : 1'b0;
        check("jtdo1", jtdo1, on_ce2 ? 1'b0 : e);
        check("jtdo2", jtdo2, on_ce2 ? e : 1'b0);
        jtck = 1'b0;
    endtask

    task automatic toggle_noshift(input int n);
        jshift = 1'b0;
        jtdi   = 1'b1;
        repeat (n) begin
            wait_clk(8);
            jtck = 1'b1;
            wait_clk(8);
            jtck = 1'b0;
        end
    endtask

    task automatic pulse_update(input int exp_pulses);
        int v0;
        jshift = 1'b0;
        wait_clk(4);
        v0      = vcount;
        jupdate = 1'b1;
        wait_clk(8);
        jupdate = 1'b0;
        wait_clk(8);
        check("valid_pulses", 128'(vcount - v0), 128'(exp_pulses));
    endtask

    task automatic transfer(input logic [127:0] val, input int n, input bit on_ce2);
        logic [63:0] prev;
        prev = exp_data;
        jce1 = !on_ce2;
        jce2 = on_ce2;
        for (int i = 0; i < n; i++) shift_bit(val[i], prev, i, on_ce2);
        pulse_update(1);
        jce1 = 1'b0;
        jce2 = 1'b0;
    endtask

    initial begin
        logic [63:0] prev;
        resn = 1'b0; jtck = 1'b0; jtdi = 1'b0; jshift = 1'b0;
        jupdate = 1'b0; jce1 = 1'b0; jce2 = 1'b0;
        wait_clk(5);
        check_outputs("reset", 64'h0, 8'd0, 2'b00, 1'b0);
        check("reset.valid", valid, 1'b0);
        check("reset.jtdo1", jtdo1, 1'b0);
        check("reset.jtdo2", jtdo2, 1'b0);
        resn = 1'b1;
        wait_clk(8);

        // Full 64-bit transfer on ER1.
        transfer(128'h0000_0000_0000_0000_DEAD_BEEF_0123_4567, 64, 1'b0);
        exp_data = 64'hDEAD_BEEF_0123_4567;
        check_outputs("full64", exp_data, 8'd64, 2'b01, 1'b0);

        // Short 8-bit transfer on ER2: new byte at the top, residue below.
        transfer(128'hA5, 8, 1'b1);
        exp_data = 64'hA5DE_ADBE_EF01_2345;
        check_outputs("short8", exp_data, 8'd8, 2'b10, 1'b0);

        // 70-bit transfer: only the last 64 bits survive.
        transfer(128'({64'hCAFE_F00D_1234_5678, 6'b101101}), 70, 1'b0);
        exp_data = 64'hCAFE_F00D_1234_5678;
        check_outputs("over70", exp_data, 8'd70, 2'b01, 1'b1);

        // Update with nothing shifted, and jtck with jshift low, both in IDLE.
        pulse_update(0);
        check_outputs("idle_upd", exp_data, 8'd70, 2'b01, 1'b1);
        jce1 = 1'b1;
        toggle_noshift(4);
        jce1 = 1'b0;
        wait_clk(8);
        check_outputs("idle_noshift", exp_data, 8'd70, 2'b01, 1'b1);
        check("idle_noshift.valid_pulses", 128'(vcount), 128'd3);

        // 0x3C split by jshift-low jtck edges that must not shift.
        prev = exp_data;
        jce1 = 1'b1;
        for (int i = 0; i < 4; i++) shift_bit(1'(8'h3C >> i), prev, i, 1'b0);
        toggle_noshift(3);
        for (int i = 4; i < 8; i++) shift_bit(1'(8'h3C >> i), prev, i, 1'b0);
        pulse_update(1);
        jce1 = 1'b0;
        exp_data = 64'h3CCA_FEF0_0D12_3456;
        check_outputs("split8", exp_data, 8'd8, 2'b01, 1'b0);

        // Reset after 20 bits discards the transfer.
        prev = exp_data;
        jce1 = 1'b1;
        for (int i = 0; i < 20; i++) shift_bit(1'(i % 3 == 0), prev, i, 1'b0);
        resn = 1'b0;
        wait_clk(2);
        check_outputs("abort_rst", 64'h0, 8'd0, 2'b00, 1'b0);
        check("abort_rst.valid", valid, 1'b0);
        check("abort_rst.jtdo1", jtdo1, 1'b0);
        jshift = 1'b0;
        jce1   = 1'b0;
        wait_clk(4);
        resn = 1'b1;
        wait_clk(8);
        exp_data = 64'h0;
        transfer(128'h1234, 16, 1'b0);
        exp_data = 64'h1234_0000_0000_0000;
        check_outputs("after_abort", exp_data, 8'd16, 2'b01, 1'b0);

        // Echo: the second transfer reads back 0x55..55 on jtdo1, then a short ER2 transfer on jtdo2.
        transfer(128'h5555_5555_5555_5555, 64, 1'b0);
        exp_data = 64'h5555_5555_5555_5555;
        check_outputs("echo_load", exp_data, 8'd64, 2'b01, 1'b0);
        transfer(128'h0F0F_0F0F_0F0F_0F0F, 64, 1'b0);
        exp_data = 64'h0F0F_0F0F_0F0F_0F0F;
        check_outputs("echo_read", exp_data, 8'd64, 2'b01, 1'b0);
        transfer(128'h81, 8, 1'b1);
        exp_data = 64'h810F_0F0F_0F0F_0F0F;
        check_outputs("echo_er2", exp_data, 8'd8, 2'b10, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
